// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an in-order pipeline. It tracks the stages after ID and drives
// stall, flush and forwarding controls, plus counters for stall cycles and flushes.
module pipe_hazard_ctrl #(
  parameter  int STAGES  = 3,
  parameter  int RESOLVE = 3,
  parameter  int NREG    = 8,
  parameter  int NSRC    = 2,
  parameter  int SELW    = $clog2(STAGES + 1),
  localparam int REGW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REGW-1:0]        id_dest,
  input  logic                   id_we,
  input  logic                   id_load,
  input  logic [NSRC*REGW-1:0]   id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   imem_stall,
  input  logic                   dmem_stall,
  input  logic                   redirect,
  output logic                   id_ready,
  output logic                   advance,
  output logic                   lu_stall,
  output logic                   kill,
  output logic [STAGES-1:0]      stage_valid,
  output logic [NSRC*SELW-1:0]   ex_fwd_sel,
  output logic [NSRC-1:0]        id_wb_bypass,
  output logic [15:0]            lu_stall_count,
  output logic [15:0]            flush_count
);

  // Index s-1 of every per-stage vector holds stage s (stage 1 = EX).
  logic [STAGES-1:0]           valid_q, valid_d;
  logic [STAGES-1:0]           we_q, we_d;
  logic [STAGES-1:0]           load_q, load_d;
  logic [STAGES-1:0][REGW-1:0] dest_q, dest_d;
  logic [NSRC*REGW-1:0]        src_q, src_d;
  logic [NSRC-1:0]             src_used_q, src_used_d;
  logic [15:0]                 lu_cnt_q, lu_cnt_d;
  logic [15:0]                 fl_cnt_q, fl_cnt_d;

  logic            mstall;
  logic [NSRC-1:0] lu_hit;
  logic            unused_load_top;

  // The load flag only matters while an instruction sits in stage 2.
  assign unused_load_top = load_q[STAGES-1];

  assign mstall = imem_stall | dmem_stall;
  // Gated by reset so that id_ready reflects only the memory stalls while reset is held.
  assign kill   = redirect & ~imem_stall & reset;

  assign lu_stall = valid_q[0] & valid_q[1] & we_q[1] & load_q[1] & (|lu_hit) & ~mstall;
  assign advance  = kill | ~mstall;
  assign id_ready = kill | (~mstall & ~lu_stall);

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [REGW-1:0] ex_src;
      logic [SELW-1:0] fwd_sel;

      assign ex_src     = src_q[gi*REGW +: REGW];
      assign lu_hit[gi] = src_used_q[gi] & (ex_src == dest_q[1]);

      // Scan from the oldest stage down so the youngest matching producer wins.
      always_comb begin
        fwd_sel = '0;
        for (int k = STAGES; k >= 2; k--) begin
          if (src_used_q[gi] && valid_q[k-1] && we_q[k-1] && (dest_q[k-1] == ex_src)) begin
            fwd_sel = SELW'(k);
          end
        end
      end

      assign ex_fwd_sel[gi*SELW +: SELW] = fwd_sel;
      assign id_wb_bypass[gi] = valid_q[STAGES-1] & we_q[STAGES-1] & id_src_used[gi] &
                                (id_src[gi*REGW +: REGW] == dest_q[STAGES-1]);
    end
  endgenerate

  always_comb begin
    valid_d    = valid_q;
    we_d       = we_q;
    load_d     = load_q;
    dest_d     = dest_q;
    src_d      = src_q;
    src_used_d = src_used_q;
    if (advance) begin
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        we_d[s]    = we_q[s-1];
        load_d[s]  = load_q[s-1];
        dest_d[s]  = dest_q[s-1];
      end
      if (kill) begin
        // Wrong-path stages younger than the resolving stage become bubbles.
        for (int s = 0; s < RESOLVE - 1; s++) begin
          valid_d[s] = 1'b0;
          we_d[s]    = 1'b0;
          load_d[s]  = 1'b0;
        end
        src_used_d = '0;
      end else if (lu_stall) begin
        valid_d[0] = valid_q[0];
        we_d[0]    = we_q[0];
        load_d[0]  = load_q[0];
        dest_d[0]  = dest_q[0];
        valid_d[1] = 1'b0;
        we_d[1]    = 1'b0;
        load_d[1]  = 1'b0;
      end else begin
        valid_d[0] = id_valid;
        we_d[0]    = id_we;
        load_d[0]  = id_load;
        dest_d[0]  = id_dest;
        src_d      = id_src;
        src_used_d = id_src_used;
      end
    end
  end

  assign lu_cnt_d = (lu_stall && (lu_cnt_q != 16'hFFFF)) ? lu_cnt_q + 16'd1 : lu_cnt_q;
  assign fl_cnt_d = (kill && (fl_cnt_q != 16'hFFFF)) ? fl_cnt_q + 16'd1 : fl_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      we_q       <= '0;
      load_q     <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      src_used_q <= '0;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      we_q       <= we_d;
      load_q     <= load_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      src_used_q <= src_used_d;
      lu_cnt_q   <= lu_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  assign stage_valid    = valid_q;
  assign lu_stall_count = lu_cnt_q;
  assign flush_count    = fl_cnt_q;

endmodule
